// File: rtl/rr_resource_arbiter.sv
// rr_resource_arbiter: round-robin owner of one shared datapath resource,
// holding each grant until done or a watchdog-forced release.
module rr_resource_arbiter #(
   parameter int NUM_REQ  = 4,
   parameter int TIMEOUT  = 64,
   parameter int TO_WIDTH = $clog2(TIMEOUT + 1)
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [NUM_REQ-1:0]         req,
   input  logic                       done,
   output logic [NUM_REQ-1:0]         grant,
   output logic [$clog2(NUM_REQ)-1:0] sel,
   output logic                       grant_valid,
   output logic                       timeout_err
);
   localparam int SW = $clog2(NUM_REQ);
   typedef enum logic {IDLE, OWNED} state_t;
   state_t state, state_n;
   logic [NUM_REQ-1:0] grant_n, cand;
   logic [SW-1:0] sel_n, ptr, ptr_n, base, win;
   logic [TO_WIDTH-1:0] wd, wd_n;
   logic terr_n, found, expire, rel;
   int idx;

   // while owned, the current owner is excluded so it cannot re-win back-to-back
   always_comb begin
      base = (state == OWNED) ? sel : ptr;
      cand = (state == OWNED) ? req & ~grant : req;
      win = '0;
      found = 1'b0;
      idx = 0;
      for (int k = NUM_REQ; k >= 1; k--) begin
         idx = (int'(base) + k) % NUM_REQ;
         if (cand[idx[SW-1:0]]) begin
            win = idx[SW-1:0];
            found = 1'b1;
         end
      end
   end

   assign expire = wd == TO_WIDTH'(TIMEOUT - 1);
   assign rel = (state == OWNED) && (done || expire);

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state <= IDLE;
         grant <= '0;
         sel <= '0;
         ptr <= SW'(NUM_REQ - 1);
         wd <= '0;
         timeout_err <= 1'b0;
      end else begin
         state <= state_n;
         grant <= grant_n;
         sel <= sel_n;
         ptr <= ptr_n;
         wd <= wd_n;
         timeout_err <= terr_n;
      end

   always_comb begin
      state_n = state;
      grant_n = grant;
      sel_n = sel;
      ptr_n = ptr;
      wd_n = wd;
      terr_n = 1'b0;
      if (state == IDLE || rel) begin
         ptr_n = rel ? sel : ptr;
         terr_n = rel && !done;
         wd_n = '0;
         state_n = found ? OWNED : IDLE;
         grant_n = found ? NUM_REQ'(1) << win : '0;
         sel_n = found ? win : sel;
      end else
         wd_n = wd + 1'b1;
   end

   always_comb grant_valid = (state == OWNED);
endmodule

// File: tb/tb_rr_resource_arbiter.sv
// tb_rr_resource_arbiter: directed stimulus, owner/pointer model checked every cycle
// plus literal expectations for each scenario.
module tb_rr_resource_arbiter;
   localparam int N = 4;
   localparam int TO = 8;
   logic clk = 0, rst_n = 1, done = 0, grant_valid, timeout_err;
   logic [N-1:0] req = '0, grant;
   logic [1:0] sel;
   int total = 0, bad = 0;
   int m_owner = -1, m_ptr = N - 1, m_age = 0, m_sel = 0;
   logic m_terr = 0;

   rr_resource_arbiter #(.NUM_REQ(N), .TIMEOUT(TO)) dut (
      .clk(clk), .rst_n(rst_n), .req(req), .done(done), .grant(grant),
      .sel(sel), .grant_valid(grant_valid), .timeout_err(timeout_err));

   always #5 clk = ~clk;

   task automatic chk(input string nm, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // first set bit searching upward from base+1, wrapping; -1 if none
   function automatic int pick(input logic [N-1:0] m, input int base);
      for (int k = 1; k <= N; k++)
         if (m[(base + k) % N]) return (base + k) % N;
      return -1;
   endfunction

   always @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         m_owner <= -1; m_ptr <= N - 1; m_age <= 0; m_sel <= 0; m_terr <= 0;
      end else if (m_owner < 0) begin
         m_terr <= 0;
         if (req != 0) begin
            m_owner <= pick(req, m_ptr);
            m_sel <= pick(req, m_ptr);
            m_age <= 0;
         end
      end else if (done || m_age == TO - 1) begin
         m_terr <= !done;
         m_ptr <= m_owner;
         m_owner <= pick(req & ~(N'(1) << m_owner), m_owner);
         if (pick(req & ~(N'(1) << m_owner), m_owner) >= 0)
            m_sel <= pick(req & ~(N'(1) << m_owner), m_owner);
         m_age <= 0;
      end else begin
         m_terr <= 0;
         m_age <= m_age + 1;
      end

   always @(negedge clk)
      if (rst_n) begin
         chk("model_grant", int'(grant), m_owner < 0 ? 0 : (1 << m_owner));
         chk("model_valid", int'(grant_valid), m_owner >= 0 ? 1 : 0);
         chk("model_sel", int'(sel), m_sel);
         chk("model_terr", int'(timeout_err), int'(m_terr));
      end

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 0; req = '0; done = 0;
      @(negedge clk);
      rst_n = 1;
   endtask

   initial begin
      #300000;
      $display("FAIL global_timeout");
      $fatal(1, "bench timed out");
   end

   initial begin
      logic [N-1:0] order[$];
      logic [N-1:0] prev;
      int idle;
      #1 rst_n = 0;
      cyc(1);
      chk("rst_grant", int'(grant), 0);
      chk("rst_sel", int'(sel), 0);
      chk("rst_valid", int'(grant_valid), 0);
      chk("rst_terr", int'(timeout_err), 0);
      rst_n = 1;
      // single requester
      req = 4'b0100;
      cyc(1);
      chk("single_grant", int'(grant), 4'b0100);
      chk("single_sel", int'(sel), 2);
      chk("single_valid", int'(grant_valid), 1);
      req = 0; done = 1;
      cyc(1);
      done = 0;
      chk("single_release", int'(grant), 0);
      chk("single_release_valid", int'(grant_valid), 0);
      // fairness with done every third cycle
      do_reset();
      req = 4'b1111;
      prev = '0; idle = 0;
      for (int i = 1; i <= 14; i++) begin
         cyc(1);
         if (grant == 0) idle++;
         if (grant != prev && grant != 0) order.push_back(grant);
         prev = grant;
         done = (i % 3 == 2);
      end
      chk("fair_count", order.size() >= 5 ? 5 : order.size(), 5);
      if (order.size() >= 5) begin
         chk("fair_0", int'(order[0]), 4'b0001);
         chk("fair_1", int'(order[1]), 4'b0010);
         chk("fair_2", int'(order[2]), 4'b0100);
         chk("fair_3", int'(order[3]), 4'b1000);
         chk("fair_4", int'(order[4]), 4'b0001);
      end
      chk("fair_no_idle", idle, 0);
      // back-to-back exclusion and wrap
      do_reset();
      req = 4'b0011;
      cyc(1);
      chk("b2b_first", int'(grant), 4'b0001);
      done = 1;
      cyc(1);
      chk("b2b_second", int'(grant), 4'b0010);
      cyc(1);
      chk("b2b_wrap", int'(grant), 4'b0001);
      chk("b2b_wrap_sel", int'(sel), 0);
      done = 0; req = 0;
      // watchdog expiry
      do_reset();
      req = 4'b0001;
      cyc(8);
      chk("wd_held", int'(grant), 4'b0001);
      chk("wd_no_early", int'(timeout_err), 0);
      cyc(1);
      chk("wd_pulse", int'(timeout_err), 1);
      chk("wd_released", int'(grant), 0);
      cyc(1);
      chk("wd_pulse_end", int'(timeout_err), 0);
      chk("wd_regrant", int'(grant), 4'b0001);
      req = 0;
      // done coincident with expiry
      do_reset();
      req = 4'b0001;
      cyc(8);
      done = 1; req = 0;
      cyc(1);
      done = 0;
      chk("wd_coinc_terr", int'(timeout_err), 0);
      chk("wd_coinc_grant", int'(grant), 0);
      // requester drops req while owning
      do_reset();
      req = 4'b1000;
      cyc(1);
      chk("drop_grant", int'(grant), 4'b1000);
      req = 0;
      cyc(3);
      chk("drop_held", int'(grant), 4'b1000);
      chk("drop_sel", int'(sel), 3);
      done = 1;
      cyc(1);
      done = 0;
      chk("drop_release", int'(grant), 0);
      // async reset mid-transaction
      do_reset();
      req = 4'b0100;
      cyc(1);
      chk("async_pre", int'(grant), 4'b0100);
      #2 rst_n = 0;
      #1;
      chk("async_grant", int'(grant), 0);
      chk("async_valid", int'(grant_valid), 0);
      chk("async_sel", int'(sel), 0);
      cyc(1);
      rst_n = 1; req = 4'b1111;
      cyc(1);
      chk("async_first", int'(grant), 4'b0001);
      req = 0; done = 1;
      cyc(1);
      done = 0;
      cyc(2);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/rr_resource_arbiter.md
Name: rr_resource_arbiter

Overview:
Round-robin arbiter that shares one datapath resource (e.g. the data-memory port or the multi-cycle MUL/DIV unit) between NUM_REQ requesters. It drives the select input of the shared parameterised input mux and the per-requester grant lines. It holds each grant until the resource signals completion, and forces release through a watchdog if completion never arrives. Sits between pipeline/stall logic and the shared unit.

Parameters:
NUM_REQ, 4, number of requesters (>=2)
TIMEOUT, 64, max cycles a grant may be held without done (>=2)
TO_WIDTH, $clog2(TIMEOUT+1), width of the watchdog counter (derived, do not override)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
req  input  NUM_REQ  request per requester, level, bit i = requester i
done  input  1  shared resource completed the current transaction (1-cycle pulse)
grant  output  NUM_REQ  registered one-hot grant; all-zero when idle
sel  output  $clog2(NUM_REQ)  index of current/last winner, wired to mux select
grant_valid  output  1  high while any grant bit is set
timeout_err  output  1  1-cycle pulse when watchdog forces a release

Behaviour:
- Reset (async, rst_n=0): grant=0, grant_valid=0, sel=0, timeout_err=0, state=IDLE, watchdog=0, priority pointer=NUM_REQ-1 (requester 0 wins first). Reset mid-transaction drops grant immediately, with no wait for done.
- States: IDLE, OWNED.
- IDLE: if req!=0, choose the winner by round-robin. Search starts at pointer+1 and wraps modulo NUM_REQ; the first set bit wins. On the next rising edge: grant=onehot(winner), sel=winner, grant_valid=1, state=OWNED, watchdog=0. Latency req->grant = 1 cycle. If req==0: stay IDLE, grant=0, sel holds its last value.
- OWNED: grant/sel frozen. Requester dropping req while owning is ignored; the grant stays until done or timeout. Watchdog increments each cycle done=0.
- done=1 in OWNED: pointer<=current winner. If other req bits (excluding the current winner) are set, grant the next round-robin winner on the same edge (back-to-back, no bubble), watchdog=0, stay OWNED. Else grant=0, grant_valid=0, state=IDLE. The current owner's own req is not considered on this edge, so it cannot immediately re-win while others wait. If no one else is requesting, it may re-win from IDLE one cycle later.
- done on the first OWNED cycle is legal and handled identically.
- done in IDLE is ignored.
- Watchdog: when the count reaches TIMEOUT-1 with done=0, the next edge releases exactly as if done=1 (pointer update, back-to-back rule) and pulses timeout_err for one cycle. done and timeout in the same cycle counts as done: no timeout_err.
- grant is always one-hot or zero. sel is always <NUM_REQ. sel changes only on a grant edge.
- Non-power-of-two NUM_REQ: indices >=NUM_REQ are never produced.

Test Plan:
- Reset/single requester: rst_n low then high, req=4'b0100 -> after 1 edge grant=0100, sel=2, grant_valid=1. done pulse -> next edge grant=0000, IDLE.
- Fairness: req=4'b1111 held, done pulsed every 3rd cycle -> grant order 0001,0010,0100,1000,0001, with no idle cycle between owners.
- Back-to-back exclusion: req=4'b0011, owner 0, done -> grant=0010 on the same edge. Owner 1 done with req=0011 still set -> grant=0001 (wrap).
- Watchdog: TIMEOUT=8, req=4'b0001, done never asserted -> timeout_err single pulse 8 cycles after grant, grant then 0000. Done and timeout coincident -> no pulse.
- Req drop while owning: owner 3, req falls to 0 -> grant stays 1000 until done.
- Async reset mid-transaction: assert rst_n=0 between edges while grant=0100 -> grant=0 immediately. After release, req=1111 -> requester 0 wins first.
